// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch up-counter.
// BCD digit type, control FSM states and the MM:SS digit bundle.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } sw_state_t;

    localparam bcd_t BCD_MAX_ONES = 4'd9;
    localparam bcd_t BCD_MAX_TENS = 4'd5;

    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } bcd_time_t;

endpackage

// File: rtl/stopwatch_up_counter_if.sv
// Command strobes in, MM:SS digits and status out.
// The button/tick side is the master, the counter the slave.
interface stopwatch_up_counter_if;
    import stopwatch_pkg::*;

    logic tick;
    logic start;
    logic stop;
    logic clear;
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
    logic running;
    logic done;
    logic wrap_pulse;

    modport master (
        output tick,
        output start,
        output stop,
        output clear,
        input  min_tens,
        input  min_ones,
        input  sec_tens,
        input  sec_ones,
        input  running,
        input  done,
        input  wrap_pulse
    );

    modport slave (
        input  tick,
        input  start,
        input  stop,
        input  clear,
        output min_tens,
        output min_ones,
        output sec_tens,
        output sec_ones,
        output running,
        output done,
        output wrap_pulse
    );

endinterface

// File: rtl/FA4.sv
// Four-bit ripple adder cell with carry in and carry out.
module FA4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    assign {Cout, S} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};

endmodule

// File: rtl/bcd_digit_inc.sv
// One BCD digit incrementer: adds en_i, rolls to 0 past limit_i.
// carry_o is raised only when an enabled step passes the limit.
module bcd_digit_inc
    import stopwatch_pkg::*;
(
    input  bcd_t digit_i,
    input  logic en_i,
    input  bcd_t limit_i,
    output bcd_t digit_o,
    output logic carry_o
);

    bcd_t sum;
    logic unused_cout;

    // digit <= 9 so the 4-bit sum never overflows
    FA4 u_fa (
        .A    (digit_i),
        .B    (4'd0),
        .Cin  (en_i),
        .S    (sum),
        .Cout (unused_cout)
    );

    assign carry_o = en_i && (digit_i == limit_i);
    assign digit_o = carry_o ? 4'd0 : sum;

endmodule

// File: rtl/stopwatch_up_counter.sv
// MM:SS BCD up-counter with start/stop/clear control FSM.
// WRAP_EN selects wrap at 59:59 or a sticky DONE state.
module stopwatch_up_counter
    import stopwatch_pkg::*;
#(
    parameter bit WRAP_EN = 1'b0
) (
    input logic                  clk,
    input logic                  reset,
    stopwatch_up_counter_if.slave sw
);

    sw_state_t state_q, state_d;
    bcd_time_t cnt_q, cnt_d;
    logic      wrap_q, wrap_d;

    logic inc_en;
    logic c_so, c_st, c_mo, c_mt;
    bcd_t n_so, n_st, n_mo, n_mt;
    logic hold_end;

    // stop, clear and the resuming start all swallow a same-cycle tick
    assign inc_en = sw.tick && !sw.clear && !sw.stop
                    && (state_q == RUN);

    bcd_digit_inc u_so (
        .digit_i (cnt_q.sec_ones),
        .en_i    (inc_en),
        .limit_i (BCD_MAX_ONES),
        .digit_o (n_so),
        .carry_o (c_so)
    );

    bcd_digit_inc u_st (
        .digit_i (cnt_q.sec_tens),
        .en_i    (c_so),
        .limit_i (BCD_MAX_TENS),
        .digit_o (n_st),
        .carry_o (c_st)
    );

    bcd_digit_inc u_mo (
        .digit_i (cnt_q.min_ones),
        .en_i    (c_st),
        .limit_i (BCD_MAX_ONES),
        .digit_o (n_mo),
        .carry_o (c_mo)
    );

    bcd_digit_inc u_mt (
        .digit_i (cnt_q.min_tens),
        .en_i    (c_mo),
        .limit_i (BCD_MAX_TENS),
        .digit_o (n_mt),
        .carry_o (c_mt)
    );

    assign hold_end = c_mt && !WRAP_EN;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;

        unique case (state_q)
            IDLE, PAUSED: begin
                if (sw.start)
                    state_d = RUN;
            end
            RUN: begin
                if (sw.stop)
                    state_d = PAUSED;
                else if (hold_end)
                    state_d = DONE;
            end
            DONE: begin
                state_d = DONE;
            end
        endcase

        if (inc_en && !hold_end)
            cnt_d = {n_mt, n_mo, n_st, n_so};

        wrap_d = c_mt && WRAP_EN;

        if (sw.clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            wrap_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    assign sw.min_tens   = cnt_q.min_tens;
    assign sw.min_ones   = cnt_q.min_ones;
    assign sw.sec_tens   = cnt_q.sec_tens;
    assign sw.sec_ones   = cnt_q.sec_ones;
    assign sw.running    = (state_q == RUN);
    assign sw.done       = (state_q == DONE);
    assign sw.wrap_pulse = wrap_q;

endmodule

// File: tb/tb_stopwatch_up_counter.sv
// Bench for stopwatch_up_counter: both WRAP_EN settings side by side
// against an elapsed-seconds model, plus directed literal checkpoints.
module tb_stopwatch_up_counter;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic clk = 1'b0;
    logic reset;
    logic c_tick, c_start, c_stop, c_clear;
    bit   chk_en;

    int n_pass = 0;
    int n_tot  = 0;

    int m_cnt[2];
    int m_st[2];
    bit m_wp[2];

    always #5 clk = ~clk;

    stopwatch_up_counter_if if0 ();
    stopwatch_up_counter_if if1 ();

    assign if0.tick  = c_tick;
    assign if0.start = c_start;
    assign if0.stop  = c_stop;
    assign if0.clear = c_clear;
    assign if1.tick  = c_tick;
    assign if1.start = c_start;
    assign if1.stop  = c_stop;
    assign if1.clear = c_clear;

    stopwatch_up_counter #(.WRAP_EN(1'b0)) u_nowrap (
        .clk   (clk),
        .reset (reset),
        .sw    (if0)
    );

    stopwatch_up_counter #(.WRAP_EN(1'b1)) u_wrap (
        .clk   (clk),
        .reset (reset),
        .sw    (if1)
    );

    function automatic logic [15:0] bcd4(input int s);
        int m;
        int x;
        m = s / 60;
        x = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic logic [18:0] get_out(input int i);
        if (i == 0)
            return {if0.min_tens, if0.min_ones, if0.sec_tens,
                    if0.sec_ones, if0.running, if0.done,
                    if0.wrap_pulse};
        return {if1.min_tens, if1.min_ones, if1.sec_tens,
                if1.sec_ones, if1.running, if1.done,
                if1.wrap_pulse};
    endfunction

    function automatic logic [18:0] model_out(input int i);
        return {bcd4(m_cnt[i]), m_st[i] == S_RUN,
                m_st[i] == S_DONE, m_wp[i]};
    endfunction

    task automatic chk(input string nm, input logic [18:0] act,
                       input logic [18:0] exp);
        n_tot++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s got=%h want=%h (mmss,run,done,wrap)",
                     nm, act, exp);
    endtask

    task automatic lit(input int i, input string nm,
                       input logic [15:0] d, input bit run,
                       input bit dn, input bit wp);
        chk($sformatf("%s_dut%0d", nm, i), get_out(i),
            {d, run, dn, wp});
    endtask

    // Model in whole elapsed seconds; digits derived by division.
    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_cnt[i] = 0;
                m_st[i]  = S_IDLE;
                m_wp[i]  = 1'b0;
            end else begin
                m_wp[i] = 1'b0;
                if (c_clear) begin
                    m_cnt[i] = 0;
                    m_st[i]  = S_IDLE;
                end else if (m_st[i] == S_RUN) begin
                    if (c_stop) begin
                        m_st[i] = S_PAUSE;
                    end else if (c_tick) begin
                        if (m_cnt[i] < 3599) begin
                            m_cnt[i] = m_cnt[i] + 1;
                        end else if (i == 1) begin
                            m_cnt[i] = 0;
                            m_wp[i]  = 1'b1;
                        end else begin
                            m_st[i] = S_DONE;
                        end
                    end
                end else if (m_st[i] != S_DONE && c_start) begin
                    m_st[i] = S_RUN;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (chk_en) begin
            #1;
            for (int i = 0; i < 2; i++)
                chk($sformatf("cycle_dut%0d", i), get_out(i),
                    model_out(i));
        end
    end

    task automatic cyc(input bit s, input bit p, input bit c,
                       input bit t);
        @(negedge clk);
        c_start = s;
        c_stop  = p;
        c_clear = c;
        c_tick  = t;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lit2(input string nm, input logic [15:0] d,
                        input bit run);
        lit(0, nm, d, run, 1'b0, 1'b0);
        lit(1, nm, d, run, 1'b0, 1'b0);
    endtask

    initial begin
        c_tick  = 1'b0;
        c_start = 1'b0;
        c_stop  = 1'b0;
        c_clear = 1'b0;
        chk_en  = 1'b0;
        reset   = 1'b0;
        #1 reset = 1'b1;
        #2;
        lit2("reset", 16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;

        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(3);
        idle();
        lit2("three_ticks", 16'h0003, 1'b1);

        ticks(56);
        idle();
        lit2("at_0059", 16'h0059, 1'b1);
        ticks(1);
        idle();
        lit2("carry_0100", 16'h0100, 1'b1);
        ticks(539);
        idle();
        lit2("at_0959", 16'h0959, 1'b1);
        ticks(1);
        idle();
        lit2("carry_1000", 16'h1000, 1'b1);
        ticks(2999);
        idle();
        lit2("at_5959", 16'h5959, 1'b1);

        ticks(1);
        idle();
        lit(0, "end_hold", 16'h5959, 1'b0, 1'b1, 1'b0);
        lit(1, "end_wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
        idle();
        lit(1, "wrap_one_cycle", 16'h0000, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        lit(0, "start_in_done", 16'h5959, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        lit2("clear_done", 16'h0000, 1'b0);

        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(5);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        lit2("stop_drops_tick", 16'h0005, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(1);
        idle();
        lit2("resume", 16'h0006, 1'b1);

        ticks(748);
        idle();
        lit2("at_1234", 16'h1234, 1'b1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        lit2("async_reset", 16'h0000, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(2);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        idle();
        lit2("clear_and_start", 16'h0000, 1'b0);

        for (int k = 0; k < 3000; k++) begin
            int r;
            r = $urandom_range(0, 99);
            cyc(r < 12, r >= 12 && r < 20,
                $urandom_range(0, 199) == 0,
                $urandom_range(0, 1) == 1);
        end
        idle();
        @(negedge clk);
        chk_en = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/stopwatch_up_counter.md
# stopwatch_up_counter

Four-digit BCD MM:SS counter that counts elapsed time upward, one step per `tick` enable pulse. It mirrors the countdown datapath: it increments digits with carry where the countdown path subtracts with borrow. It sits between the 1 Hz tick generator and the seven-segment display driver in the stopwatch system. A small control FSM handles start/stop/clear commands from the debounced buttons.

## Interface
Parameters:
- `WRAP_EN`, default 0. If 1, count wraps from 59:59 to 00:00 and keeps running. If 0, count stops at 59:59 and the block enters DONE.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tick`  in  1  single-cycle count enable (1 Hz strobe).
- `start`  in  1  single-cycle command: begin or resume counting.
- `stop`  in  1  single-cycle command: pause counting.
- `clear`  in  1  single-cycle command: return to 00:00 and IDLE.
- `min_tens`  out  4  BCD minutes tens, range 0–5.
- `min_ones`  out  4  BCD minutes ones, range 0–9.
- `sec_tens`  out  4  BCD seconds tens, range 0–5.
- `sec_ones`  out  4  BCD seconds ones, range 0–9.
- `running`  out  1  high while the state is RUN.
- `done`  out  1  level, high while the state is DONE (`WRAP_EN`=0 only).
- `wrap_pulse`  out  1  one-cycle pulse when 59:59 wraps to 00:00 (`WRAP_EN`=1 only).

## Operation
- FSM states: IDLE, RUN, PAUSED, DONE.
- Transitions:
  - IDLE + `start` -> RUN.
  - RUN + `stop` -> PAUSED.
  - PAUSED + `start` -> RUN.
  - RUN + `tick` at 59:59 with `WRAP_EN`=0 -> DONE.
  - Any state + `clear` -> IDLE, with digits forced to 00:00.
- Ignored commands: `start` in RUN or DONE; `stop` in IDLE, PAUSED or DONE.
- Command priority: `clear` > `stop` > `start` > `tick`.
- Tick handling:
  - Only a `tick` sampled in RUN changes the digits.
  - A tick coincident with `stop`, `clear` or the IDLE/PAUSED->RUN `start` is dropped.
- Increment rule: `sec_ones` +1. Each digit carries to the next when it passes its limit:
  - `sec_ones`: 9 -> 0, carry into `sec_tens`.
  - `sec_tens`: 5 -> 0, carry into `min_ones`.
  - `min_ones`: 9 -> 0, carry into `min_tens`.
  - `min_tens`: 5 -> 0, generates the terminal carry.
- Terminal carry:
  - `WRAP_EN`=1: digits become 00:00, `wrap_pulse` is asserted, state stays RUN.
  - `WRAP_EN`=0: digits hold 59:59 and state becomes DONE.
- Digits never leave their BCD range. Out-of-range values are unreachable from reset.
- Reset mid-count: all digits go to 0 and state to IDLE immediately (asynchronous), regardless of the current state.

## Timing
- Reset values: all digits 0, `running`=0, `done`=0, `wrap_pulse`=0, state IDLE.
- Latency:
  - Digits update on the clock edge that samples `tick`; the new value is visible in the following cycle.
  - State changes and `running`/`done` take effect on the edge that samples the command.
- `wrap_pulse` is registered and asserted for exactly one cycle, coincident with digits first showing 00:00.
- `done` rises in the same cycle the state becomes DONE. It stays high until `clear` or `reset`.
- Back-to-back ticks on consecutive cycles are each counted. There is no minimum tick spacing.

## Structure
- Shared package `stopwatch_pkg` holds:
  - `bcd_t` (logic [3:0]),
  - the FSM enum `sw_state_t` {IDLE, RUN, PAUSED, DONE},
  - constants `BCD_MAX_ONES`=9 and `BCD_MAX_TENS`=5.
- Sub-module `bcd_digit_inc` (inputs: digit, enable, limit; outputs: next digit, carry).
  - Built on the existing `FA4` adder with B=0 and Cin=enable.
  - Instantiated four times, chained by carry.
- Top module contains the FSM, the digit registers and the wrap/done logic.

## Test plan
- Reset, then `start`, then 3 ticks -> reads 00:03 and `running`=1.
- Preload path via ticks to 00:59, then 1 tick -> 01:00. From 09:59 -> 10:00.
- `WRAP_EN`=0, count at 59:59, then tick -> digits stay 59:59, `done`=1, `running`=0. A following `start` is ignored. `clear` -> 00:00 and IDLE.
- `WRAP_EN`=1, count at 59:59, then tick -> 00:00, `wrap_pulse` high for 1 cycle, state stays RUN.
- At 00:05 in RUN, assert `stop`+`tick` in the same cycle -> stays 00:05, state PAUSED. Then `start`, then tick -> 00:06.
- At 12:34 in RUN, assert `reset` between clock edges -> outputs 0 and IDLE before the next edge. `clear`+`start` in the same cycle -> IDLE at 00:00.
